// File: rtl/bridge_pkg.sv
// bridge_pkg: shared constants and FSM state types for the SRAM-to-AXI bridge
package bridge_pkg;
    localparam logic [3:0] ID_INST     = 4'd0;
    localparam logic [3:0] ID_DATA     = 4'd1;
    localparam logic [3:0] LEN_SINGLE  = 4'd0;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] LOCK_NORMAL = 2'b00;
    localparam logic [3:0] CACHE_NONE  = 4'd0;
    localparam logic [2:0] PROT_NONE   = 3'd0;

    typedef enum logic {AR_IDLE, AR_SEND} ar_state_e;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;
endpackage

// File: rtl/axi_write_ctrl.sv
// axi_write_ctrl: single-beat AXI3 store engine (AW/W issue, B response) for the data port
module axi_write_ctrl
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_i,
    input  logic [1:0]  size_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        accept_o,
    output logic        done_o,
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic [3:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic [1:0]  awlock_o,
    output logic [3:0]  awcache_o,
    output logic [2:0]  awprot_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic        bvalid_i,
    output logic        bready_o
);
    w_state_e    state_q, state_d;
    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q, w_pend_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  size_q, size_d;

    assign awid_o    = ID_DATA;
    assign awaddr_o  = addr_q;
    assign awlen_o   = LEN_SINGLE;
    assign awsize_o  = size_q;
    assign awburst_o = BURST_INCR;
    assign awlock_o  = LOCK_NORMAL;
    assign awcache_o = CACHE_NONE;
    assign awprot_o  = PROT_NONE;
    assign awvalid_o = (state_q == W_SEND) & aw_pend_q;
    assign wid_o     = ID_DATA;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign wlast_o   = 1'b1;
    assign wvalid_o  = (state_q == W_SEND) & w_pend_q;
    assign bready_o  = 1'b1;

    // Next state: latch the store, let AW and W retire independently, then wait for B
    always_comb begin
        state_d   = state_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        size_d    = size_q;
        accept_o  = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            W_IDLE: if (req_i) begin
                accept_o  = 1'b1;
                addr_d    = addr_i;
                wdata_d   = wdata_i;
                wstrb_d   = wstrb_i;
                size_d    = {1'b0, size_i};
                aw_pend_d = 1'b1;
                w_pend_d  = 1'b1;
                state_d   = W_SEND;
            end
            W_SEND: begin
                aw_pend_d = aw_pend_q & ~awready_i;
                w_pend_d  = w_pend_q & ~wready_i;
                state_d   = (aw_pend_d | w_pend_d) ? W_SEND : W_RESP;
            end
            W_RESP: if (bvalid_i) begin
                done_o  = 1'b1;
                state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

    // State and latched store registers; reset drops any in-flight store
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= W_IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            size_q    <= '0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            size_q    <= size_d;
        end
    end
endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: merges the fetch and data SRAM-like ports onto one AXI3 master
module sram_axi_bridge
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    ar_state_e   ar_state_q, ar_state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  arid_q, arid_d;
    logic [2:0]  arsize_q, arsize_d;
    logic        inst_busy_q, inst_busy_d;
    logic        data_busy_q, data_busy_d;
    logic        data_rd_go, inst_go, w_req, w_accept, w_done;
    logic        inst_r_ok, data_r_ok;
    logic        unused_ok;

    // Fetch-side write fields, response codes and IDs on B are deliberately dropped
    assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

    assign data_rd_go = (ar_state_q == AR_IDLE) & data_sram_req & ~data_sram_wr & ~data_busy_q;
    assign inst_go    = (ar_state_q == AR_IDLE) & inst_sram_req & ~inst_busy_q & ~data_rd_go;
    assign w_req      = data_sram_req & data_sram_wr & ~data_busy_q;
    assign inst_r_ok  = rvalid & (rid == ID_INST) & inst_busy_q;
    assign data_r_ok  = rvalid & (rid == ID_DATA) & data_busy_q;

    assign inst_sram_addr_ok = inst_go;
    assign data_sram_addr_ok = data_rd_go | w_accept;
    assign inst_sram_data_ok = inst_r_ok;
    assign data_sram_data_ok = data_r_ok | w_done;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = LEN_SINGLE;
    assign arsize  = arsize_q;
    assign arburst = BURST_INCR;
    assign arlock  = LOCK_NORMAL;
    assign arcache = CACHE_NONE;
    assign arprot  = PROT_NONE;
    assign arvalid = (ar_state_q == AR_SEND);
    assign rready  = 1'b1;

    axi_write_ctrl u_wr (
        .clk       (clk),
        .resetn    (resetn),
        .req_i     (w_req),
        .size_i    (data_sram_size),
        .wstrb_i   (data_sram_wstrb),
        .addr_i    (data_sram_addr),
        .wdata_i   (data_sram_wdata),
        .accept_o  (w_accept),
        .done_o    (w_done),
        .awid_o    (awid),
        .awaddr_o  (awaddr),
        .awlen_o   (awlen),
        .awsize_o  (awsize),
        .awburst_o (awburst),
        .awlock_o  (awlock),
        .awcache_o (awcache),
        .awprot_o  (awprot),
        .awvalid_o (awvalid),
        .awready_i (awready),
        .wid_o     (wid),
        .wdata_o   (wdata),
        .wstrb_o   (wstrb),
        .wlast_o   (wlast),
        .wvalid_o  (wvalid),
        .wready_i  (wready),
        .bvalid_i  (bvalid),
        .bready_o  (bready)
    );

    // AR arbitration (data read beats fetch) and busy tracking for both ports
    always_comb begin
        ar_state_d  = ar_state_q;
        araddr_d    = araddr_q;
        arid_d      = arid_q;
        arsize_d    = arsize_q;
        inst_busy_d = inst_go | (inst_busy_q & ~inst_r_ok);
        data_busy_d = data_rd_go | w_accept | (data_busy_q & ~data_sram_data_ok);
        case (ar_state_q)
            AR_IDLE: begin
                ar_state_d = (data_rd_go | inst_go) ? AR_SEND : AR_IDLE;
                araddr_d   = data_rd_go ? data_sram_addr : inst_go ? inst_sram_addr : araddr_q;
                arid_d     = data_rd_go ? ID_DATA : inst_go ? ID_INST : arid_q;
                arsize_d   = data_rd_go ? {1'b0, data_sram_size} : inst_go ? {1'b0, inst_sram_size} : arsize_q;
            end
            AR_SEND: ar_state_d = arready ? AR_IDLE : AR_SEND;
            default: ar_state_d = AR_IDLE;
        endcase
    end

    // AR channel registers and busy flags; reset abandons everything in flight
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_state_q  <= AR_IDLE;
            araddr_q    <= '0;
            arid_q      <= '0;
            arsize_q    <= '0;
            inst_busy_q <= 1'b0;
            data_busy_q <= 1'b0;
        end else begin
            ar_state_q  <= ar_state_d;
            araddr_q    <= araddr_d;
            arid_q      <= arid_d;
            arsize_q    <= arsize_d;
            inst_busy_q <= inst_busy_d;
            data_busy_q <= data_busy_d;
        end
    end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: directed scenarios plus a randomized run against a transaction-level model
module tb_sram_axi_bridge;
    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic [3:0]  arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {logic [31:0] addr; logic [3:0] id; logic [2:0] size;} ar_t;
    typedef struct {logic [3:0] id; logic [31:0] data;} r_t;
    ar_t ar_q[$];
    r_t  r_q[$];
    logic inst_out, data_out, wr_pend, aw_done, w_done, b_pend;
    logic [31:0] m_waddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [2:0]  m_wsize;
    logic exp_drd, exp_dwr, exp_i, exp_iok, exp_dok;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        resetn = 1'b0;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2; inst_sram_wstrb = 0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2; data_sram_wstrb = 0;
        data_sram_addr = 0; data_sram_wdata = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; rid = 0; rdata = 0;
        rresp = 0; rlast = 1; bvalid = 0; bid = 1; bresp = 0;
        {inst_out, data_out, wr_pend, aw_done, w_done, b_pend} = '0;
        m_waddr = 0; m_wdata = 0; m_wstrb = 0; m_wsize = 0;

        // reset state and constant outputs
        tick; tick; #1;
        chk("rst_arvalid", arvalid, 0); chk("rst_awvalid", awvalid, 0); chk("rst_wvalid", wvalid, 0);
        chk("rst_iaok", inst_sram_addr_ok, 0); chk("rst_daok", data_sram_addr_ok, 0);
        chk("rst_araddr", araddr, 0); chk("rst_awaddr", awaddr, 0); chk("rst_wdata", wdata, 0);
        chk("rst_wstrb", wstrb, 0); chk("const_rready", rready, 1); chk("const_bready", bready, 1);
        chk("const_wlast", wlast, 1); chk("const_awid", awid, 1); chk("const_wid", wid, 1);
        chk("const_arburst", arburst, 1); chk("const_awburst", awburst, 1); chk("const_arlen", arlen, 0);
        resetn = 1'b1;

        // fetch only, arready after three valid cycles
        tick; inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000; #1;
        chk("f_iaok", inst_sram_addr_ok, 1); chk("f_arvalid_T", arvalid, 0);
        tick; inst_sram_req = 0; #1;
        chk("f_arvalid1", arvalid, 1); chk("f_araddr", araddr, 32'h1c00_0000);
        chk("f_arid", arid, 0); chk("f_arsize", arsize, 2);
        tick; #1; chk("f_arvalid2", arvalid, 1);
        tick; arready = 1; #1; chk("f_arvalid3", arvalid, 1);
        tick; arready = 0; rvalid = 1; rid = 0; rdata = 32'h0280_0413; #1;
        chk("f_arvalid_done", arvalid, 0); chk("f_idok", inst_sram_data_ok, 1);
        chk("f_irdata", inst_sram_rdata, 32'h0280_0413); chk("f_ddok", data_sram_data_ok, 0);
        tick; rvalid = 0; #1; chk("f_idok_end", inst_sram_data_ok, 0);

        // simultaneous data read and fetch, then interleaved R beats
        tick; data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1000;
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0004; #1;
        chk("a_daok", data_sram_addr_ok, 1); chk("a_iaok_lose", inst_sram_addr_ok, 0);
        tick; data_sram_req = 0; arready = 1; #1;
        chk("a_arvalid", arvalid, 1); chk("a_arid_data", arid, 1);
        chk("a_araddr", araddr, 32'h1000); chk("a_iaok_send", inst_sram_addr_ok, 0);
        tick; arready = 0; #1;
        chk("a_iaok_late", inst_sram_addr_ok, 1); chk("a_arvalid_idle", arvalid, 0);
        tick; inst_sram_req = 0; arready = 1; #1;
        chk("a_arid_inst", arid, 0); chk("a_araddr_i", araddr, 32'h1c00_0004);
        tick; arready = 0; rvalid = 1; rid = 1; rdata = 32'hcafe_0001; #1;
        chk("i_ddok", data_sram_data_ok, 1); chk("i_idok0", inst_sram_data_ok, 0);
        chk("i_drdata", data_sram_rdata, 32'hcafe_0001);
        tick; rid = 0; rdata = 32'hbeef_0002; #1;
        chk("i_idok", inst_sram_data_ok, 1); chk("i_ddok0", data_sram_data_ok, 0);
        chk("i_irdata", inst_sram_rdata, 32'hbeef_0002);
        tick; rvalid = 0; #1;
        chk("i_idok_end", inst_sram_data_ok, 0); chk("i_ddok_end", data_sram_data_ok, 0);

        // store with late wready, a load waiting behind it
        tick; data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h2000;
        data_sram_wstrb = 4'hf; data_sram_wdata = 32'h1234_5678; #1;
        chk("s_daok", data_sram_addr_ok, 1); chk("s_awvalid_T", awvalid, 0);
        tick; data_sram_wr = 0; data_sram_addr = 32'h3000; awready = 1; #1;
        chk("s_awvalid", awvalid, 1); chk("s_wvalid", wvalid, 1); chk("s_awaddr", awaddr, 32'h2000);
        chk("s_wdata", wdata, 32'h1234_5678); chk("s_wstrb", wstrb, 4'hf); chk("s_awsize", awsize, 2);
        chk("s_ld_block1", data_sram_addr_ok, 0);
        tick; awready = 0; #1;
        chk("s_aw_drop", awvalid, 0); chk("s_w_hold", wvalid, 1); chk("s_ld_block2", data_sram_addr_ok, 0);
        tick; wready = 1; #1; chk("s_w_hold2", wvalid, 1);
        tick; wready = 0; #1;
        chk("s_w_drop", wvalid, 0); chk("s_ld_block3", data_sram_addr_ok, 0); chk("s_no_dok", data_sram_data_ok, 0);
        tick; bvalid = 1; #1;
        chk("s_dok", data_sram_data_ok, 1); chk("s_ld_block4", data_sram_addr_ok, 0);
        tick; bvalid = 0; #1;
        chk("s_dok_once", data_sram_data_ok, 0); chk("s_ld_accept", data_sram_addr_ok, 1);
        tick; data_sram_req = 0; arready = 1; #1;
        chk("s_ld_arvalid", arvalid, 1); chk("s_ld_arid", arid, 1); chk("s_ld_araddr", araddr, 32'h3000);
        tick; arready = 0; rvalid = 1; rid = 1; rdata = 32'h55aa_33cc; #1;
        chk("s_ld_dok", data_sram_data_ok, 1); chk("s_ld_rdata", data_sram_rdata, 32'h55aa_33cc);
        tick; rvalid = 0;

        // fetch and store accepted together, then reset mid-flight and a stray beat
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0100;
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h4000;
        data_sram_wdata = 32'ha5a5_a5a5; data_sram_wstrb = 4'h3; #1;
        chk("r_iaok", inst_sram_addr_ok, 1); chk("r_daok", data_sram_addr_ok, 1);
        tick; inst_sram_req = 0; data_sram_req = 0; #1;
        chk("r_arvalid", arvalid, 1); chk("r_awvalid", awvalid, 1);
        tick; resetn = 0;
        tick; resetn = 1; rvalid = 1; rid = 0; rdata = 32'hdead_beef; #1;
        chk("x_idok", inst_sram_data_ok, 0); chk("x_ddok", data_sram_data_ok, 0);
        chk("x_arvalid", arvalid, 0); chk("x_awvalid", awvalid, 0); chk("x_wvalid", wvalid, 0);
        chk("x_araddr", araddr, 0); chk("x_awaddr", awaddr, 0); chk("x_wdata", wdata, 0); chk("x_wstrb", wstrb, 0);
        tick; rvalid = 0;

        // randomized traffic against a transaction-level model
        for (int c = 0; c < 3000; c++) begin
            tick;
            inst_sram_req  = 1'($urandom_range(0, 1));
            inst_sram_addr = $urandom;
            inst_sram_size = 2'($urandom_range(0, 2));
            data_sram_req  = 1'($urandom_range(0, 1));
            data_sram_wr   = 1'($urandom_range(0, 1));
            data_sram_addr = $urandom;
            data_sram_size = 2'($urandom_range(0, 2));
            data_sram_wstrb = 4'($urandom);
            data_sram_wdata = $urandom;
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            rvalid  = (r_q.size() != 0) && ($urandom_range(0, 1) == 1);
            rid     = rvalid ? r_q[0].id : 4'($urandom);
            rdata   = rvalid ? r_q[0].data : $urandom;
            bvalid  = b_pend && ($urandom_range(0, 1) == 1);
            #1;
            exp_drd = data_sram_req && !data_sram_wr && !data_out && ar_q.size() == 0;
            exp_dwr = data_sram_req && data_sram_wr && !data_out;
            exp_i   = inst_sram_req && !inst_out && ar_q.size() == 0 && !exp_drd;
            exp_iok = rvalid && rid == 0;
            exp_dok = (rvalid && rid == 1) || bvalid;
            chk("rnd_iaok", inst_sram_addr_ok, exp_i);
            chk("rnd_daok", data_sram_addr_ok, exp_drd || exp_dwr);
            chk("rnd_arvalid", arvalid, ar_q.size() != 0);
            if (ar_q.size() != 0) begin
                chk("rnd_araddr", araddr, ar_q[0].addr);
                chk("rnd_arid", arid, ar_q[0].id);
                chk("rnd_arsize", arsize, ar_q[0].size);
            end
            chk("rnd_awvalid", awvalid, wr_pend && !aw_done);
            chk("rnd_wvalid", wvalid, wr_pend && !w_done);
            if (wr_pend) begin
                chk("rnd_awaddr", awaddr, m_waddr); chk("rnd_awsize", awsize, m_wsize);
                chk("rnd_wdata", wdata, m_wdata); chk("rnd_wstrb", wstrb, m_wstrb);
            end
            chk("rnd_idok", inst_sram_data_ok, exp_iok);
            chk("rnd_ddok", data_sram_data_ok, exp_dok);
            if (exp_iok) chk("rnd_irdata", inst_sram_rdata, rdata);
            if (rvalid && rid == 1) chk("rnd_drdata", data_sram_rdata, rdata);
            if (ar_q.size() != 0 && arready) begin
                r_q.push_back('{id: ar_q[0].id, data: $urandom});
                void'(ar_q.pop_front());
            end
            if (exp_drd) begin
                ar_q.push_back('{addr: data_sram_addr, id: 4'd1, size: {1'b0, data_sram_size}});
                data_out = 1;
            end
            if (exp_i) begin
                ar_q.push_back('{addr: inst_sram_addr, id: 4'd0, size: {1'b0, inst_sram_size}});
                inst_out = 1;
            end
            if (rvalid) begin
                if (rid == 0) inst_out = 0; else data_out = 0;
                void'(r_q.pop_front());
            end
            if (wr_pend && awready) aw_done = 1;
            if (wr_pend && wready) w_done = 1;
            if (wr_pend && aw_done && w_done && !bvalid) b_pend = 1;
            if (bvalid) {b_pend, wr_pend, aw_done, w_done, data_out} = '0;
            if (exp_dwr) begin
                wr_pend = 1; data_out = 1;
                m_waddr = data_sram_addr; m_wdata = data_sram_wdata;
                m_wstrb = data_sram_wstrb; m_wsize = {1'b0, data_sram_size};
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the core's two SRAM-like request ports (instruction fetch, data access) into a single AXI3 master interface. It sits between the pipeline's fetch/memory stages and the SoC AXI interconnect. It feeds the fetch stage its `addr_ok`/`data_ok`/`rdata` handshake and carries loads and stores for the memory stage.

## Interface
- Parameters: none. All constants live in the shared package.
- `clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `inst_sram_req`, `inst_sram_wr`, `inst_sram_size[1:0]`, `inst_sram_wstrb[3:0]`, `inst_sram_addr[31:0]`, `inst_sram_wdata[31:0]` in: fetch request. `wr`/`wstrb`/`wdata` are ignored; every fetch is treated as a read.
- `inst_sram_addr_ok` out 1: request accepted this cycle.
- `inst_sram_data_ok` out 1: read data valid this cycle.
- `inst_sram_rdata` out 32: read data.
- `data_sram_req`, `data_sram_wr`, `data_sram_size[1:0]`, `data_sram_wstrb[3:0]`, `data_sram_addr[31:0]`, `data_sram_wdata[31:0]` in: load/store request.
- `data_sram_addr_ok`, `data_sram_data_ok` out 1; `data_sram_rdata` out 32: same meaning as the fetch port.
- `arid[3:0]`, `araddr[31:0]`, `arsize[2:0]`, `arvalid` out; `arready` in: read address channel.
- `rid[3:0]`, `rdata[31:0]`, `rresp[1:0]`, `rlast`, `rvalid` in; `rready` out: read data channel.
- `awid[3:0]`, `awaddr[31:0]`, `awsize[2:0]`, `awvalid` out; `awready` in: write address channel.
- `wid[3:0]`, `wdata[31:0]`, `wstrb[3:0]`, `wlast`, `wvalid` out; `wready` in: write data channel.
- `bid[3:0]`, `bresp[1:0]`, `bvalid` in; `bready` out: write response channel.
- Constant outputs: `arlen`/`awlen` = 0, `arburst`/`awburst` = 2'b01, `arlock`/`awlock` = 0, `arcache`/`awcache` = 0, `arprot`/`awprot` = 0, `awid` = 1, `wid` = 1, `wlast` = 1, `rready` = 1, `bready` = 1.

## Operation
- Outstanding limits:
  - Fetch port: at most 1 outstanding read (`inst_busy`).
  - Data port: at most 1 outstanding transaction of either kind (`data_busy`). This keeps `data_ok` in request order and rules out RAW hazards through the interconnect.
- AR FSM:
  - States: `AR_IDLE`, `AR_SEND`.
  - In `AR_IDLE`, the bridge selects a read. A data read (`data_sram_req & ~data_sram_wr & ~data_busy`) has priority over a fetch (`inst_sram_req & ~inst_busy`).
  - On acceptance it asserts the matching `addr_ok` combinationally and latches `araddr`, `arid` (0 = inst, 1 = data) and `arsize = {1'b0,size}`, then moves to `AR_SEND`.
  - In `AR_SEND`, `arvalid` = 1 and the channel is held stable until `arready`, then returns to `AR_IDLE`.
- W FSM:
  - States: `W_IDLE`, `W_SEND`, `W_RESP`.
  - In `W_IDLE`, `data_sram_req & data_sram_wr & ~data_busy` asserts `data_sram_addr_ok` and latches addr, size, wstrb and wdata.
  - In `W_SEND`, `awvalid` and `wvalid` are raised together. Each drops independently on its own handshake. When both have completed, the FSM moves to `W_RESP`.
  - In `W_RESP`, `bvalid` pulses `data_sram_data_ok` and the FSM returns to `W_IDLE`.
- A data read and a data write are never accepted in the same cycle (`data_busy` rule). A fetch read and a data write may both be accepted in the same cycle.
- Return path (combinational):
  - `rvalid & rid==0 & inst_busy` drives `inst_sram_data_ok`.
  - `rvalid & rid==1 & data_busy` drives `data_sram_data_ok`.
  - `rdata` is passed to both ports.
  - A busy flag clears on the edge after its `data_ok`.
- Responses whose busy flag is clear (for example stale beats after a reset) are consumed and ignored.
- `rresp`/`bresp` are ignored.

## Timing
- `addr_ok` is asserted in the request cycle T. The AXI valid is asserted from T+1. `data_ok` is asserted in the same cycle as `rvalid`/`bvalid`.
- A new request on the same port gets its earliest `addr_ok` in the cycle after that port's `data_ok`.
- Reset values:
  - All valids, `addr_ok`, `data_ok` and busy flags are 0.
  - FSMs are in their IDLE states.
  - Latched address, data and strobe registers are 0.
  - Reset mid-transaction abandons all in-flight state.
- If `arready` or `awready`/`wready` are already high in the first valid cycle, the handshake completes in 1 cycle.

## Structure
- Package `bridge_pkg`:
  - AXI ID constants `ID_INST` = 0, `ID_DATA` = 1.
  - Constant burst/cache/prot values.
  - Enum types for the AR and W FSM states.
- Sub-module `axi_write_ctrl` contains the W FSM plus the AW/W/B channel logic. The top level keeps AR arbitration and the return path.

## Test plan
- Fetch only: `inst_req` @0x1c000000, `arready` delayed 3 cycles, then `rvalid` with `rid` = 0 and `rdata` = 0x02800413 -> `addr_ok` at T, `arvalid` T+1..T+3, `inst_data_ok` with matching data, `arid` = 0.
- Simultaneous data read @0x1000 and fetch in the same cycle -> data wins (`arid` = 1). The fetch gets `addr_ok` only after `arready` clears `AR_SEND`.
- Store @0x2000, `wstrb` = 0xF, `wdata` = 0x12345678, `wready` 2 cycles after `awready` -> single `bvalid` yields exactly one `data_ok`. `wlast` = 1.
- Store outstanding, then load request -> no `data_sram_addr_ok` until the cycle after the store's `data_ok`.
- Interleaved responses: data `rid` = 1 then inst `rid` = 0 on consecutive cycles -> each port's `data_ok` fires once, in its own cycle, with the right data.
- Reset asserted with AR and W pending, then a stray `rvalid` `rid` = 0 arrives -> no `data_ok`, all outputs at their reset values.
